ebr_dp_cfg_model: RTL and testbench

//  Parametrised behavioural model of a true dual-port EBR with per-port write mode, optional output

---
 rtl/ebr_model_pkg.sv | 11 +
 rtl/ebr_port_rd.sv | 43 ++++
 rtl/ebr_dp_cfg_model.sv | 74 +++++++
 tb/tb_ebr_dp_cfg_model.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ebr_model_pkg.sv
// ebr_model_pkg: shared write-mode, register-mode and width constants for the dual-port EBR model
package ebr_model_pkg;
    typedef enum logic [1:0] {
        WM_NORMAL          = 2'd0,
        WM_WRITETHROUGH    = 2'd1,
        WM_READBEFOREWRITE = 2'd2
    } wm_e;
    localparam int REG_NOREG  = 0;
    localparam int REG_OUTREG = 1;
    localparam int MAX_DATA_W = 36;
endpackage

// File: rtl/ebr_port_rd.sv
// ebr_port_rd: per-port read path of the EBR model -- write-mode read latch plus optional output register
module ebr_port_rd
    import ebr_model_pkg::*;
#(
    parameter int  DATA_W    = 18,
    parameter wm_e WRITEMODE = WM_NORMAL,
    parameter int  REGMODE   = REG_NOREG
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              oce_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] do_o
);
    logic [DATA_W-1:0] lat_q, lat_d;

    // rd_data_i is the pre-edge array word, so read-before-write shares the plain read path
    always_comb
        lat_d = !we_i                           ? rd_data_i :
                (WRITEMODE == WM_WRITETHROUGH)    ? wr_data_i :
                (WRITEMODE == WM_READBEFOREWRITE) ? rd_data_i : lat_q;

    always_ff @(posedge clk_i)
        if (rst_i)     lat_q <= '0;
        else if (en_i) lat_q <= lat_d;

    generate
        if (REGMODE == REG_OUTREG) begin : g_outreg
            logic [DATA_W-1:0] out_q;
            always_ff @(posedge clk_i)
                if (rst_i)      out_q <= '0;
                else if (oce_i) out_q <= lat_q;
            assign do_o = out_q;
        end else begin : g_noreg
            logic unused_oce;
            assign unused_oce = oce_i;
            assign do_o       = lat_q;
        end
    endgenerate
endmodule

// File: rtl/ebr_dp_cfg_model.sv
// ebr_dp_cfg_model: true dual-port EBR model with per-port write mode, output register and chip select.
// Define EBR_COLLISION_FLAG_EN to build the registered same-address collision flag on COLL.
module ebr_dp_cfg_model
    import ebr_model_pkg::*;
#(
    parameter int         DATA_W      = 18,
    parameter int         ADDR_W      = 10,
    parameter wm_e        WRITEMODE_A = WM_NORMAL,
    parameter wm_e        WRITEMODE_B = WM_NORMAL,
    parameter int         REGMODE_A   = REG_NOREG,
    parameter int         REGMODE_B   = REG_NOREG,
    parameter logic [2:0] CSDECODE_A  = 3'b000,
    parameter logic [2:0] CSDECODE_B  = 3'b000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CEA,
    input  logic              OCEA,
    input  logic              WEA,
    input  logic [2:0]        CSA,
    input  logic [ADDR_W-1:0] ADA,
    input  logic [DATA_W-1:0] DIA,
    output logic [DATA_W-1:0] DOA,
    input  logic              CEB,
    input  logic              OCEB,
    input  logic              WEB,
    input  logic [2:0]        CSB,
    input  logic [ADDR_W-1:0] ADB,
    input  logic [DATA_W-1:0] DIB,
    output logic [DATA_W-1:0] DOB,
    output logic              COLL
);
    generate
        if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_width
            $error("ebr_dp_cfg_model: DATA_W out of range");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              en_a, en_b, wr_a, wr_b;

    assign en_a = CEA && (CSA == CSDECODE_A);
    assign en_b = CEB && (CSB == CSDECODE_B);
    assign wr_a = en_a && WEA;
    // port A owns the word when both ports write the same address
    assign wr_b = en_b && WEB && !(wr_a && ADA == ADB);

    always_ff @(posedge CLK)
        if (!RST) begin
            if (wr_a) mem_q[ADA] <= DIA;
            if (wr_b) mem_q[ADB] <= DIB;
        end

    ebr_port_rd #(.DATA_W(DATA_W), .WRITEMODE(WRITEMODE_A), .REGMODE(REGMODE_A)) u_rd_a (
        .clk_i(CLK), .rst_i(RST), .en_i(en_a), .we_i(WEA), .oce_i(OCEA),
        .rd_data_i(mem_q[ADA]), .wr_data_i(DIA), .do_o(DOA)
    );

    ebr_port_rd #(.DATA_W(DATA_W), .WRITEMODE(WRITEMODE_B), .REGMODE(REGMODE_B)) u_rd_b (
        .clk_i(CLK), .rst_i(RST), .en_i(en_b), .we_i(WEB), .oce_i(OCEB),
        .rd_data_i(mem_q[ADB]), .wr_data_i(DIB), .do_o(DOB)
    );

`ifdef EBR_COLLISION_FLAG_EN
    logic coll_q, coll_d;
    always_comb coll_d = en_a && en_b && (ADA == ADB) && (WEA || WEB);
    always_ff @(posedge CLK)
        if (RST) coll_q <= 1'b0;
        else     coll_q <= coll_d;
    assign COLL = coll_q;
`else
    assign COLL = 1'b0;
`endif
endmodule

// File: tb/tb_ebr_dp_cfg_model.sv
// tb_ebr_dp_cfg_model: directed checks of write modes, output register, chip select and arbitration
module tb_ebr_dp_cfg_model;
    import ebr_model_pkg::*;
`ifdef EBR_COLLISION_FLAG_EN
    localparam logic COLL_EN = 1'b1;
`else
    localparam logic COLL_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    // u_dut: A writethrough, B read-before-write with CSDECODE_B=101, both NOREG
    logic cea, ocea, wea, ceb, oceb, web, coll;
    logic [2:0] csa, csb;
    logic [3:0] ada, adb;
    logic [17:0] dia, dib, doa, dob;
    // u_dut2: A normal NOREG, B normal OUTREG
    logic n_cea, n_ocea, n_wea, n_ceb, n_oceb, n_web, n_coll;
    logic [2:0] n_csa, n_csb;
    logic [3:0] n_ada, n_adb;
    logic [17:0] n_dia, n_dib, n_doa, n_dob;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    ebr_dp_cfg_model #(.DATA_W(18), .ADDR_W(4), .WRITEMODE_A(WM_WRITETHROUGH),
        .WRITEMODE_B(WM_READBEFOREWRITE), .REGMODE_A(REG_NOREG), .REGMODE_B(REG_NOREG),
        .CSDECODE_A(3'b000), .CSDECODE_B(3'b101)) u_dut (
        .CLK(clk), .RST(rst),
        .CEA(cea), .OCEA(ocea), .WEA(wea), .CSA(csa), .ADA(ada), .DIA(dia), .DOA(doa),
        .CEB(ceb), .OCEB(oceb), .WEB(web), .CSB(csb), .ADB(adb), .DIB(dib), .DOB(dob),
        .COLL(coll)
    );

    ebr_dp_cfg_model #(.DATA_W(18), .ADDR_W(4), .WRITEMODE_A(WM_NORMAL),
        .WRITEMODE_B(WM_NORMAL), .REGMODE_A(REG_NOREG), .REGMODE_B(REG_OUTREG),
        .CSDECODE_A(3'b000), .CSDECODE_B(3'b000)) u_dut2 (
        .CLK(clk), .RST(rst),
        .CEA(n_cea), .OCEA(n_ocea), .WEA(n_wea), .CSA(n_csa), .ADA(n_ada), .DIA(n_dia), .DOA(n_doa),
        .CEB(n_ceb), .OCEB(n_oceb), .WEB(n_web), .CSB(n_csb), .ADB(n_adb), .DIB(n_dib), .DOB(n_dob),
        .COLL(n_coll)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        {cea, wea, ceb, web, n_cea, n_wea, n_ceb, n_web} = '0;
        csa = 3'b000; csb = 3'b101; n_csa = 3'b000; n_csb = 3'b000;
    endtask

    task automatic a_op(input logic we, input logic [3:0] ad, input logic [17:0] d);
        cea = 1'b1; wea = we; ada = ad; dia = d;
    endtask

    task automatic b_op(input logic [2:0] cs, input logic we, input logic [3:0] ad, input logic [17:0] d);
        ceb = 1'b1; csb = cs; web = we; adb = ad; dib = d;
    endtask

    task automatic randomize_inputs;
        {cea, ocea, wea, ceb, oceb, web} = 6'($urandom);
        {n_cea, n_ocea, n_wea, n_ceb, n_oceb, n_web} = 6'($urandom);
        {csa, csb, n_csa, n_csb} = 12'($urandom);
        {ada, adb, n_ada, n_adb} = 16'($urandom);
        {dia, dib} = 36'({$urandom, $urandom});
        {n_dia, n_dib} = 36'({$urandom, $urandom});
        ada = 4'd0; wea = 1'b1;
    endtask

    initial begin
        tick;
        {ocea, oceb, n_ocea, n_oceb} = '0;
        {ada, adb, n_ada, n_adb} = '0;
        {dia, dib, n_dia, n_dib} = '0;
        tick;
        rst = 1'b0;
        a_op(1'b1, 4'd0, 18'h00155); tick;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_inputs;
            tick;
        end
        check("rst_doa", doa, 0);
        check("rst_dob", dob, 0);
        check("rst_n_doa", n_doa, 0);
        check("rst_n_dob", n_dob, 0);
        check("rst_coll", coll, 0);
        rst = 1'b0; n_oceb = 1'b0; ocea = 1'b0; oceb = 1'b0; n_ocea = 1'b0;
        a_op(1'b0, 4'd0, 18'h0); tick;
        check("rst_mem0_kept", doa, 18'h00155);

        a_op(1'b1, 4'd5, 18'h000AA); tick;
        check("wt_preload", doa, 18'h000AA);
        a_op(1'b1, 4'd5, 18'h3FFFF); tick;
        check("wt_write", doa, 18'h3FFFF);
        a_op(1'b1, 4'd5, 18'h000AA); tick;
        b_op(3'b101, 1'b1, 4'd5, 18'h3FFFF); tick;
        check("rbw_write", dob, 18'h000AA);
        b_op(3'b101, 1'b0, 4'd5, 18'h0); tick;
        check("rbw_readback", dob, 18'h3FFFF);

        n_cea = 1'b1; n_wea = 1'b1; n_ada = 4'd5; n_dia = 18'h000AA; tick;
        n_cea = 1'b1; n_ada = 4'd5; tick;
        check("normal_read", n_doa, 18'h000AA);
        n_cea = 1'b1; n_wea = 1'b1; n_ada = 4'd5; n_dia = 18'h3FFFF; tick;
        check("normal_hold", n_doa, 18'h000AA);
        n_cea = 1'b1; n_ada = 4'd5; tick;
        check("normal_readback", n_doa, 18'h3FFFF);

        n_cea = 1'b1; n_wea = 1'b1; n_ada = 4'd7; n_dia = 18'h01234; tick;
        n_oceb = 1'b1; n_ceb = 1'b1; n_adb = 4'd7; tick;
        check("outreg_edge1", n_dob, 0);
        tick;
        check("outreg_edge2", n_dob, 18'h01234);
        n_cea = 1'b1; n_wea = 1'b1; n_ada = 4'd8; n_dia = 18'h00BEE; tick;
        n_ceb = 1'b1; n_adb = 4'd8; tick;
        check("outreg_prev", n_dob, 18'h01234);
        n_oceb = 1'b0; tick;
        check("outreg_oce_hold", n_dob, 18'h01234);
        n_oceb = 1'b1; tick;
        check("outreg_oce_resume", n_dob, 18'h00BEE);

        a_op(1'b1, 4'd9, 18'h00011); b_op(3'b101, 1'b1, 4'd9, 18'h00022); tick;
        check("dual_coll", coll, 32'(COLL_EN));
        check("dual_doa", doa, 18'h00011);
        tick;
        check("dual_coll_clear", coll, 0);
        b_op(3'b101, 1'b0, 4'd9, 18'h0); tick;
        check("dual_a_wins", dob, 18'h00011);

        a_op(1'b1, 4'd10, 18'h00555); tick;
        b_op(3'b100, 1'b1, 4'd10, 18'h03333); tick;
        check("cs_miss_hold", dob, 18'h00011);
        b_op(3'b101, 1'b0, 4'd10, 18'h0); tick;
        check("cs_miss_nowrite", dob, 18'h00555);
        b_op(3'b101, 1'b1, 4'd10, 18'h03333); tick;
        b_op(3'b101, 1'b0, 4'd10, 18'h0); tick;
        check("cs_hit_write", dob, 18'h03333);

        a_op(1'b1, 4'd3, 18'h00001); tick;
        a_op(1'b1, 4'd3, 18'h00F0F); b_op(3'b101, 1'b0, 4'd3, 18'h0); tick;
        check("cross_old", dob, 18'h00001);
        check("cross_coll", coll, 32'(COLL_EN));
        b_op(3'b101, 1'b0, 4'd3, 18'h0); tick;
        check("cross_new", dob, 18'h00F0F);
        check("cross_coll_clear", coll, 0);

        a_op(1'b1, 4'd15, 18'h2AAAA); tick;
        b_op(3'b101, 1'b0, 4'd15, 18'h0); tick;
        check("top_addr", dob, 18'h2AAAA);
        b_op(3'b101, 1'b0, 4'd0, 18'h0); tick;
        check("addr0_no_alias", dob, 18'h00155);
        check("n_coll_quiet", n_coll, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
